// File: rtl/pll_lock_mon.sv
// pll_lock_mon: lock and ratio monitor for the 8X sample clock.
// Counts clk cycles per ref_clk period and declares lock after a run of
// in-tolerance periods. While locked, it produces a divide-by-RATIO tick that
// is re-aligned to every reference rising edge and flywheels between edges.
module pll_lock_mon #(
    parameter int RATIO    = 8,
    parameter int TOL      = 0,
    parameter int LOCK_CNT = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             RST_n,
    input  logic             ref_clk,
    output logic             locked,
    output logic [CNT_W-1:0] meas_period,
    output logic             err_pulse,
    output logic             ref_rise,
    output logic             div_tick,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    localparam int GR_W   = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
    localparam int PH_W   = $clog2(RATIO + 1);
    localparam int LO_INT = (RATIO > TOL) ? (RATIO - TOL) : 0;

    // Window bounds are one bit wider than the counter so RATIO+TOL cannot wrap.
    localparam logic [CNT_W:0]   PERIOD_LO = (CNT_W + 1)'(LO_INT);
    localparam logic [CNT_W:0]   PERIOD_HI = (CNT_W + 1)'(RATIO + TOL);
    localparam logic [GR_W-1:0]  GR_MAX    = GR_W'(LOCK_CNT);
    localparam logic [PH_W-1:0]  PH_MAX    = PH_W'(RATIO);
    localparam logic [PH_W-1:0]  PH_ONE    = PH_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // sync_q[0]=s1, sync_q[1]=s2, sync_q[2]=s3 (edge-detect stage)
    logic [2:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] meas_q, meas_d;
    logic [GR_W-1:0]  good_run_q, good_run_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    state_e           state_q, state_d;
    logic             locked_q;
    logic             err_q, err_d;
    logic             cnt_sat;
    logic             period_good;

    assign ref_rise    = sync_q[1] & ~sync_q[2];
    assign cnt_sat     = &cnt_q;
    assign period_good = ({1'b0, cnt_q} >= PERIOD_LO) && ({1'b0, cnt_q} <= PERIOD_HI);

    // The tick is gated by the current state so it never pulses outside LOCKED.
    assign div_tick    = (state_q == LOCKED) && (ref_rise || (ph_q == PH_MAX));

    assign locked      = locked_q;
    assign meas_period = meas_q;
    assign err_pulse   = err_q;
    assign dbg_state_o = state_q;

    // Bring ref_clk into the clk domain and keep one extra stage for edge detection.
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], ref_clk};
        end
    end

    // Period counter restarts on each rise and saturates; phase counter wraps at RATIO.
    always_comb begin
        cnt_d = cnt_q;
        ph_d  = ph_q + 1'b1;
        if (ref_rise) begin
            cnt_d = CNT_ONE;
        end else if (!cnt_sat) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (ref_rise || (ph_q == PH_MAX)) begin
            ph_d = PH_ONE;
        end
    end

    // Lock FSM: judge each completed period, track the good run, catch a dead reference.
    always_comb begin
        state_d    = state_q;
        good_run_d = good_run_q;
        meas_d     = meas_q;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                // The first rise only starts a period; there is nothing to judge yet.
                if (ref_rise) begin
                    state_d    = MEASURE;
                    good_run_d = '0;
                end
            end
            MEASURE, LOCKED: begin
                if (ref_rise) begin
                    // A rise on a saturated count still lands here and fails the window.
                    meas_d = cnt_q;
                    if (period_good) begin
                        if (good_run_q != GR_MAX) begin
                            good_run_d = good_run_q + 1'b1;
                        end
                        if (good_run_d == GR_MAX) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        err_d      = 1'b1;
                        good_run_d = '0;
                        state_d    = MEASURE;
                    end
                end else if (cnt_sat) begin
                    err_d      = 1'b1;
                    good_run_d = '0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                good_run_d = '0;
            end
        endcase
    end

    // Datapath registers: period count, phase count, last measurement.
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            cnt_q  <= '0;
            ph_q   <= '0;
            meas_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            ph_q   <= ph_d;
            meas_q <= meas_d;
        end
    end

    // Control registers: state, good run, lock level and error pulse.
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            state_q    <= IDLE;
            good_run_q <= '0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            good_run_q <= good_run_d;
            locked_q   <= (state_d == LOCKED);
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_pll_lock_mon.sv
// Bench for pll_lock_mon: two instances (TOL=0 and TOL=1) share clk, reset and
// ref_clk. A timeline model predicts every output each cycle; phase-end literals
// pin the model to hand-worked numbers.
module tb_pll_lock_mon;

    localparam int RATIO    = 8;
    localparam int LOCK_CNT = 4;
    localparam int CNT_W    = 8;
    localparam int CNT_MAX  = 255;
    localparam int S_IDLE   = 0;
    localparam int S_MEAS   = 1;
    localparam int S_LOCK   = 2;

    logic             clk     = 1'b0;
    logic             rst_n   = 1'b0;
    logic             ref_clk = 1'b0;
    logic             locked_w [2];
    logic [CNT_W-1:0] meas_w   [2];
    logic             err_w    [2];
    logic             rise_w   [2];
    logic             tick_w   [2];
    logic [1:0]       st_w     [2];

    pll_lock_mon #(.RATIO(8), .TOL(0), .LOCK_CNT(4), .CNT_W(8)) dut0 (
        .clk(clk), .RST_n(rst_n), .ref_clk(ref_clk),
        .locked(locked_w[0]), .meas_period(meas_w[0]), .err_pulse(err_w[0]),
        .ref_rise(rise_w[0]), .div_tick(tick_w[0]), .dbg_state_o(st_w[0])
    );

    pll_lock_mon #(.RATIO(8), .TOL(1), .LOCK_CNT(4), .CNT_W(8)) dut1 (
        .clk(clk), .RST_n(rst_n), .ref_clk(ref_clk),
        .locked(locked_w[1]), .meas_period(meas_w[1]), .err_pulse(err_w[1]),
        .ref_rise(rise_w[1]), .div_tick(tick_w[1]), .dbg_state_o(st_w[1])
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int idx, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", name, idx, act, exp, $time);
        end
    endtask

    // Values seen by the DUT on each rising clk edge.
    logic ref_smp = 1'b0;
    logic rst_smp = 1'b0;
    always @(posedge clk) begin
        ref_smp <= ref_clk;
        rst_smp <= rst_n;
    end

    // ---------------- timeline model ----------------
    int   tol_of [2] = '{0, 1};
    int   m_mode [2];
    int   m_good [2];
    int   m_meas [2];
    logic m_err  [2];
    int   k;        // active clk edges since reset release
    int   last;     // cycle in which the previous ref_rise was visible
    logic smp1, smp2, pend;

    // Phase counters taken from DUT outputs, compared with hand-worked literals.
    int   err_cnt [2];
    int   tick_cnt[2];
    int   rise_cnt0, lock_rise_idx, lock_delay, since_rise, err_meas0, err_lock0;
    logic prev_lock0;

    task automatic model_reset();
        k = 0; last = 0; smp1 = 1'b0; smp2 = 1'b0; pend = 1'b0;
        prev_lock0 = 1'b0; since_rise = 0;
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = S_IDLE; m_good[i] = 0; m_meas[i] = 0; m_err[i] = 1'b0;
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 2; i++) begin
            err_cnt[i] = 0; tick_cnt[i] = 0;
        end
        rise_cnt0 = 0; lock_rise_idx = -1; lock_delay = -1;
        err_meas0 = -1; err_lock0 = -1;
    endtask

    // Per-cycle compare against the model, sampled on the falling edge.
    initial begin
        logic rise_k;
        logic exp_tick;
        int   period;
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n || !rst_smp) begin
                model_reset();
                for (int i = 0; i < 2; i++) begin
                    check("rst_locked", i, locked_w[i], 0);
                    check("rst_meas",   i, meas_w[i],   0);
                    check("rst_err",    i, err_w[i],    0);
                    check("rst_rise",   i, rise_w[i],   0);
                    check("rst_tick",   i, tick_w[i],   0);
                end
            end else begin
                k++;
                // A reference edge sampled between edges k-2 and k-1 shows up now.
                rise_k = smp1 & ~smp2;
                for (int i = 0; i < 2; i++) begin
                    m_err[i] = 1'b0;
                    if (pend) begin
                        period = (k - 1 - last > CNT_MAX) ? CNT_MAX : (k - 1 - last);
                        if (m_mode[i] == S_IDLE) begin
                            m_mode[i] = S_MEAS;
                            m_good[i] = 0;
                        end else begin
                            m_meas[i] = period;
                            if (period >= RATIO - tol_of[i] && period <= RATIO + tol_of[i]) begin
                                if (m_good[i] < LOCK_CNT) m_good[i]++;
                                if (m_good[i] == LOCK_CNT) m_mode[i] = S_LOCK;
                            end else begin
                                m_err[i]  = 1'b1;
                                m_good[i] = 0;
                                m_mode[i] = S_MEAS;
                            end
                        end
                    end else if (m_mode[i] != S_IDLE && (k - 1 - last) >= CNT_MAX) begin
                        m_err[i]  = 1'b1;
                        m_good[i] = 0;
                        m_mode[i] = S_IDLE;
                    end
                end
                if (pend) last = k - 1;
                for (int i = 0; i < 2; i++) begin
                    exp_tick = (m_mode[i] == S_LOCK) && (rise_k || ((k - last) % RATIO == 0));
                    check("locked",   i, locked_w[i], (m_mode[i] == S_LOCK) ? 1 : 0);
                    check("meas",     i, meas_w[i],   m_meas[i]);
                    check("err",      i, err_w[i],    m_err[i]);
                    check("ref_rise", i, rise_w[i],   rise_k);
                    check("div_tick", i, tick_w[i],   exp_tick);
                    check("state",    i, st_w[i],     m_mode[i]);
                    err_cnt[i]  += err_w[i];
                    tick_cnt[i] += tick_w[i];
                end
                if (err_w[0]) begin
                    err_meas0 = meas_w[0];
                    err_lock0 = locked_w[0];
                end
                if (locked_w[0] && !prev_lock0 && lock_rise_idx < 0) begin
                    lock_rise_idx = rise_cnt0;
                    lock_delay    = since_rise + 1;
                end
                prev_lock0 = locked_w[0];
                if (rise_w[0]) begin
                    rise_cnt0++;
                    since_rise = 0;
                end else begin
                    since_rise++;
                end
                pend = rise_k;
                smp2 = smp1;
                smp1 = ref_smp;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All stimulus changes land 2 ns after a rising clk edge.
    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic ref_periods(input int per, input int n);
        for (int p = 0; p < n; p++) begin
            ref_clk = 1'b1;
            tick_n(per / 2);
            ref_clk = 1'b0;
            tick_n(per - per / 2);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        clear_counts();
        rst_n   = 1'b0;
        ref_clk = 1'b0;
        tick_n(3);
        check("reset_locked", 0, locked_w[0], 0);
        check("reset_meas",   0, meas_w[0],   0);
        check("reset_state",  1, st_w[1],     0);
        rst_n = 1'b1;
        clear_counts();

        // Exact 8X reference: lock one cycle after the 5th rise.
        ref_periods(8, 7);
        check("p80_locked",     0, locked_w[0],   1);
        check("p80_locked",     1, locked_w[1],   1);
        check("p80_meas",       0, meas_w[0],     8);
        check("p80_err_count",  0, err_cnt[0],    0);
        check("p80_rise_count", 0, rise_cnt0,     7);
        check("p80_lock_rise",  0, lock_rise_idx, 5);
        check("p80_lock_delay", 0, lock_delay,    1);
        check("p80_tick_count", 0, tick_cnt[0],   2);

        // One 70 ns period: TOL=0 drops lock and relocks after 4 good periods.
        clear_counts();
        ref_periods(7, 1);
        ref_periods(8, 5);
        check("short_err_count", 0, err_cnt[0], 1);
        check("short_err_meas",  0, err_meas0,  7);
        check("short_err_lock",  0, err_lock0,  0);
        check("short_err_count", 1, err_cnt[1], 0);
        check("short_relocked",  0, locked_w[0], 1);
        check("short_locked",    1, locked_w[1], 1);

        // Asynchronous reset in the middle of a period.
        ref_clk = 1'b1;
        tick_n(3);
        check("pre_rst_locked", 0, locked_w[0], 1);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("async_rst_locked", i, locked_w[i], 0);
            check("async_rst_all", i,
                  int'({locked_w[i], err_w[i], rise_w[i], tick_w[i], meas_w[i], st_w[i]}), 0);
        end
        ref_clk = 1'b0;
        tick_n(3);
        rst_n = 1'b1;

        // 90 ns reference: TOL=0 errors every rise from #2, TOL=1 locks and flywheels.
        clear_counts();
        ref_periods(9, 6);
        check("p90_err_count",  0, err_cnt[0],  5);
        check("p90_meas",       0, meas_w[0],   9);
        check("p90_locked",     0, locked_w[0], 0);
        check("p90_tick_count", 0, tick_cnt[0], 0);
        check("p90_locked",     1, locked_w[1], 1);
        check("p90_err_count",  1, err_cnt[1],  0);
        check("p90_tick_count", 1, tick_cnt[1], 2);

        // Back to 80 ns so both instances are locked.
        clear_counts();
        ref_periods(8, 6);
        check("back80_err_count", 0, err_cnt[0],  1);
        check("back80_err_count", 1, err_cnt[1],  0);
        check("back80_locked",    0, locked_w[0], 1);
        check("back80_locked",    1, locked_w[1], 1);

        // Stop the reference: flywheel ticks until the 255-cycle timeout.
        clear_counts();
        ref_clk = 1'b0;
        tick_n(300);
        for (int i = 0; i < 2; i++) begin
            check("stop_err_count",  i, err_cnt[i],  1);
            check("stop_locked",     i, locked_w[i], 0);
            check("stop_state",      i, st_w[i],     0);
            check("stop_tick_count", i, tick_cnt[i], 31);
        end

        // Restart at 80 ns: full lock sequence again.
        clear_counts();
        ref_periods(8, 6);
        check("restart_locked",     0, locked_w[0],   1);
        check("restart_locked",     1, locked_w[1],   1);
        check("restart_err_count",  0, err_cnt[0],    0);
        check("restart_err_count",  1, err_cnt[1],    0);
        check("restart_lock_rise",  0, lock_rise_idx, 5);
        check("restart_lock_delay", 0, lock_delay,    1);

        tick_n(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
